// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
// Holds the transfer FSM encoding and the counter/index width helpers.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_arb_state_t;

    // Width of a counter that must hold the value 'cycles'; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after last_grant and
// wraps, so the most recently served requester has the lowest priority.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             en,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IDX_W'((32'(last_grant) + k) % N);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among N_REQ requesters with round-robin grant,
// a registered SETUP/ACCESS sequence and an optional pready timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ-1:0]                  req_write,
    input  logic [N_REQ*APB_ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*APB_DATA_WIDTH-1:0]   req_wdata,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [APB_DATA_WIDTH-1:0]         rsp_rdata,
    output logic                              rsp_slverr,
    output logic                              timeout,
    output logic [APB_ADDR_WIDTH-1:0]         paddr,
    output logic                              psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [APB_DATA_WIDTH-1:0]         pwdata,
    input  logic [APB_DATA_WIDTH-1:0]         prdata,
    input  logic                              pready,
    input  logic                              pslverr
);

    localparam int unsigned IdxW = idx_width(N_REQ);
    localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast  = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_REQ - 1);
    localparam bit              TmoEn    = (TIMEOUT_CYCLES != 0);

    apb_arb_state_t state_q, state_d;

    logic [IdxW-1:0]           last_grant_q, last_grant_d;
    logic [N_REQ-1:0]          gnt_q, gnt_d;
    logic [N_REQ-1:0]          req_ready_q, req_ready_d;
    logic [N_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_slverr_q, rsp_slverr_d;
    logic                      timeout_q, timeout_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [CntW-1:0]           cnt_q, cnt_d;

    logic [N_REQ-1:0]          arb_grant;
    logic                      arb_en;
    logic [IdxW-1:0]           grant_idx;
    logic [APB_ADDR_WIDTH-1:0] sel_addr;
    logic [APB_DATA_WIDTH-1:0] sel_wdata;
    logic                      sel_write;

    // No new grant in the cycle req_ready is pulsing; that cycle launches SETUP instead.
    assign arb_en = (state_q == ST_IDLE) && (req_ready_q == '0);

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IdxW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .grant      (arb_grant)
    );

    always_comb begin
        grant_idx = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (arb_grant[i]) begin
                grant_idx = IdxW'(i);
                sel_addr  = req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                sel_wdata = req_wdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                sel_write = req_write[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_slverr_d = 1'b0;
        timeout_d    = 1'b0;
        paddr_d      = paddr_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_ready_q != '0) begin
                    psel_d  = 1'b1;
                    state_d = ST_SETUP;
                end else if (arb_grant != '0) begin
                    req_ready_d  = arb_grant;
                    gnt_d        = arb_grant;
                    last_grant_d = grant_idx;
                    paddr_d      = sel_addr;
                    pwdata_d     = sel_wdata;
                    pwrite_d     = sel_write;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = gnt_q;
                    rsp_rdata_d  = pwrite_q ? '0 : prdata;
                    rsp_slverr_d = pslverr;
                    state_d      = ST_IDLE;
                end else if (TmoEn && (cnt_q == CntLast)) begin
                    // This is the TIMEOUT_CYCLES-th ACCESS cycle without pready.
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    rsp_valid_d  = gnt_q;
                    rsp_slverr_d = 1'b1;
                    timeout_d    = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LastIdx;
            gnt_q        <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            timeout_q    <= 1'b0;
            paddr_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
            timeout_q    <= timeout_d;
            paddr_q      <= paddr_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign timeout    = timeout_q;
    assign paddr      = paddr_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed transfers push expected grants and
// responses into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_apb_master_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int N   = 2;
    localparam int TMO = 4;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          tmo;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_slverr, timeout;
    logic [AW-1:0]   paddr;
    logic            psel, penable, pwrite;
    logic [DW-1:0]   pwdata, prdata;
    logic            pready, pslverr;

    exp_t gnt_q[$];
    exp_t rsp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_gnt = 0;
    int n_rsp = 0;
    int slv_waits = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic          slv_err = 1'b0;

    apb_master_arbiter #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .timeout    (timeout),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    task automatic push_exp(input logic [N-1:0] g, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] rd,
                            input logic err, input logic tmo);
        exp_t e;
        e.gnt = g; e.addr = a; e.write = w; e.wdata = wd;
        e.lat = lat; e.rdata = rd; e.slverr = err; e.tmo = tmo;
        gnt_q.push_back(e);
        rsp_q.push_back(e);
    endtask

    task automatic wait_count(input string name, input bit use_rsp, input int target);
        int k = 0;
        while (((use_rsp ? n_rsp : n_gnt) < target) && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 60) note_fail(name);
    endtask

    // Single requester transfer; expected latency/data/error given by the caller.
    task automatic single(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] rd,
                          input logic err, input int exp_lat, input logic [DW-1:0] exp_rd,
                          input logic exp_err, input logic exp_tmo);
        int bg = n_gnt;
        int br = n_rsp;
        slv_waits = waits;
        slv_rdata = rd;
        slv_err   = err;
        push_exp(N'(1 << i), a, w, wd, exp_lat, exp_rd, exp_err, exp_tmo);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = wd;
        req_write[i]          = w;
        req_valid[i]          = 1'b1;
        wait_count("grant_wait", 1'b0, bg + 1);
        // Scramble the payload once accepted; the DUT must keep the latched copy.
        req_valid[i]          = 1'b0;
        req_addr[i*AW +: AW]  = 32'hFFFF_FFFF;
        req_wdata[i*DW +: DW] = ~wd;
        req_write[i]          = ~w;
        wait_count("rsp_wait", 1'b1, br + 1);
        @(posedge clk);
        #1;
    endtask

    // APB slave model: holds pready low for slv_waits ACCESS cycles.
    initial begin
        int wcnt = 0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (psel && penable) begin
                if (wcnt >= slv_waits) begin
                    pready  = 1'b1;
                    pslverr = slv_err;
                end else begin
                    pready = 1'b0;
                    wcnt++;
                end
            end else begin
                pready = 1'b0; pslverr = 1'b0; wcnt = 0;
            end
            prdata = slv_rdata;
        end
    end

    // Monitor / scoreboard.
    initial begin
        int   rr_cyc = 0;
        logic psel_d1 = 1'b0;
        logic pen_d1 = 1'b0;
        logic [AW-1:0] cur_addr = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_ready != '0) begin
                    if (gnt_q.size() == 0) note_fail("unexpected_grant");
                    else begin
                        e = gnt_q.pop_front();
                        check("req_ready", 32'(req_ready), 32'(e.gnt));
                        check("paddr_at_grant", paddr, e.addr);
                        check("pwrite_at_grant", 32'(pwrite), 32'(e.write));
                        if (e.write) check("pwdata_at_grant", pwdata, e.wdata);
                        cur_addr = e.addr;
                    end
                    rr_cyc = cyc;
                    n_gnt++;
                end
                if (psel && !psel_d1) begin
                    check("psel_rise_lat", 32'(cyc - rr_cyc), 32'd1);
                    check("penable_low_in_setup", 32'(penable), 32'd0);
                end
                if (penable && !pen_d1) begin
                    check("penable_rise_lat", 32'(cyc - rr_cyc), 32'd2);
                    check("paddr_in_access", paddr, cur_addr);
                end
                if (rsp_valid != '0) begin
                    if (rsp_q.size() == 0) note_fail("unexpected_rsp");
                    else begin
                        e = rsp_q.pop_front();
                        check("rsp_valid", 32'(rsp_valid), 32'(e.gnt));
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_slverr", 32'(rsp_slverr), 32'(e.slverr));
                        check("timeout", 32'(timeout), 32'(e.tmo));
                        check("rsp_lat", 32'(cyc - rr_cyc), 32'(e.lat));
                        check("psel_low_at_rsp", 32'(psel), 32'd0);
                    end
                    n_rsp++;
                end else if (timeout) begin
                    note_fail("timeout_without_rsp");
                end
            end
            psel_d1 = psel;
            pen_d1  = penable;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bg;
        int br;
        int k;
        rst = 1'b1;
        req_valid = 2'b11;
        req_write = '0;
        req_addr  = {32'h0000_0200, 32'h0000_0100};
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_psel", 32'(psel), 32'd0);
        check("reset_penable", 32'(penable), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_paddr", paddr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait write, read with 2 waits, write with slave error (rdata must be 0).
        single(0, 1'b1, 32'h10, 32'hA5A5_0001, 0, 32'h5555_5555, 1'b0, 3, 32'h0, 1'b0, 1'b0);
        single(1, 1'b0, 32'h20, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        single(1, 1'b1, 32'h24, 32'h0BAD_0000, 0, 32'h7777_0000, 1'b1, 3, 32'h0, 1'b1, 1'b0);

        // Contention: both held for four transfers -> grants 0,1,0,1.
        slv_waits = 0; slv_err = 1'b0; slv_rdata = 32'hCAFE_0001;
        req_addr  = {32'h0000_0204, 32'h0000_0100};
        req_wdata = {32'h0, 32'h0000_0011};
        req_write = 2'b01;
        for (int t = 0; t < 2; t++) begin
            push_exp(2'b01, 32'h100, 1'b1, 32'h11, 3, 32'h0, 1'b0, 1'b0);
            push_exp(2'b10, 32'h204, 1'b0, 32'h0, 3, 32'hCAFE_0001, 1'b0, 1'b0);
        end
        bg = n_gnt; br = n_rsp;
        req_valid = 2'b11;
        wait_count("contention_grants", 1'b0, bg + 4);
        req_valid = '0;
        wait_count("contention_rsps", 1'b1, br + 4);
        @(posedge clk);
        #1;

        // Timeout with pready stuck low, then pready arriving in the 4th ACCESS cycle.
        single(0, 1'b0, 32'h30, 32'h0, 1000, 32'h9999_9999, 1'b0, 6, 32'h0, 1'b1, 1'b1);
        single(1, 1'b0, 32'h34, 32'h0, 3, 32'h1234_5678, 1'b0, 6, 32'h1234_5678, 1'b0, 1'b0);
        single(0, 1'b1, 32'h38, 32'h0000_BEEF, 0, 32'h0, 1'b0, 3, 32'h0, 1'b0, 1'b0);

        // Reset during ACCESS: bus drops, no response, requester 0 regains priority.
        slv_waits = 1000;
        push_exp(2'b01, 32'h40, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        bg = n_gnt;
        req_addr[0 +: AW] = 32'h40;
        req_write[0] = 1'b0;
        req_valid = 2'b01;
        wait_count("abort_grant", 1'b0, bg + 1);
        req_valid = '0;
        k = 0;
        while (!penable && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 20) note_fail("abort_penable_wait");
        rsp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_psel", 32'(psel), 32'd0);
        check("abort_penable", 32'(penable), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        slv_waits = 0;
        slv_rdata = 32'h0BB0_0BB0;
        req_addr  = {32'h0000_0500, 32'h0000_0400};
        req_write = 2'b00;
        push_exp(2'b01, 32'h400, 1'b0, 32'h0, 3, 32'h0BB0_0BB0, 1'b0, 1'b0);
        push_exp(2'b10, 32'h500, 1'b0, 32'h0, 3, 32'h0BB0_0BB0, 1'b0, 1'b0);
        bg = n_gnt; br = n_rsp;
        req_valid = 2'b11;
        wait_count("post_reset_grants", 1'b0, bg + 2);
        req_valid = '0;
        wait_count("post_reset_rsps", 1'b1, br + 2);

        repeat (6) @(posedge clk);
        @(negedge clk);
        check("grant_queue_drained", 32'(gnt_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
